// File: rtl/mips_define.sv
// Shared MIPS definitions: mul/div op encoding, SOP30-SOP37 decode constants
// and the mul/div controller state type.
package mips_define;

  // Bit 3 = D-variant, bit 2 = divide, bit 1 = unsigned, bit 0 = high half / remainder.
  typedef enum logic [3:0] {
    OP_MUL   = 4'd0,  OP_MUH   = 4'd1,  OP_MULU  = 4'd2,  OP_MUHU  = 4'd3,
    OP_DIV   = 4'd4,  OP_MOD   = 4'd5,  OP_DIVU  = 4'd6,  OP_MODU  = 4'd7,
    OP_DMUL  = 4'd8,  OP_DMUH  = 4'd9,  OP_DMULU = 4'd10, OP_DMUHU = 4'd11,
    OP_DDIV  = 4'd12, OP_DMOD  = 4'd13, OP_DDIVU = 4'd14, OP_DMODU = 4'd15
  } muldiv_op_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_PREP, ST_RUN, ST_FIX, ST_DONE
  } muldiv_state_t;

  localparam logic [5:0] FUNCT_SOP30 = 6'b011000;
  localparam logic [5:0] FUNCT_SOP31 = 6'b011001;
  localparam logic [5:0] FUNCT_SOP32 = 6'b011010;
  localparam logic [5:0] FUNCT_SOP33 = 6'b011011;
  localparam logic [5:0] FUNCT_SOP34 = 6'b011100;
  localparam logic [5:0] FUNCT_SOP35 = 6'b011101;
  localparam logic [5:0] FUNCT_SOP36 = 6'b011110;
  localparam logic [5:0] FUNCT_SOP37 = 6'b011111;

  localparam logic [4:0] SHAMT_LO = 5'b00010;
  localparam logic [4:0] SHAMT_HI = 5'b00011;

  // The low three funct bits of SOP3x line up with the D/divide/unsigned op bits.
  function automatic muldiv_op_t sop_to_muldiv_op(input logic [5:0] funct,
                                                  input logic [4:0] shamt);
    return muldiv_op_t'({funct[2], funct[1], funct[0], shamt == SHAMT_HI});
  endfunction

endpackage

// File: rtl/mips_muldiv_iter.sv
// One radix-2 step: shift-add for multiply, restoring subtract for divide,
// sharing a single adder.
module mips_muldiv_iter #(
  parameter int XLEN = 64
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] m,
  output logic [XLEN-1:0] hi_next,
  output logic [XLEN-1:0] lo_next
);

  logic [XLEN:0]   acc_in;
  logic [XLEN:0]   addend;
  logic [XLEN+1:0] sum;
  logic            take;

  always_comb begin
    if (is_div) begin
      acc_in = {hi, lo[XLEN-1]};
      addend = ~{1'b0, m};
    end else begin
      acc_in = {1'b0, hi};
      addend = lo[0] ? {1'b0, m} : '0;
    end
    // For divide the carry-out is set exactly when the shifted remainder >= divisor.
    sum  = {1'b0, acc_in} + {1'b0, addend} + {{(XLEN+1){1'b0}}, is_div};
    take = sum[XLEN+1];
    if (is_div) begin
      hi_next = take ? sum[XLEN-1:0] : acc_in[XLEN-1:0];
      lo_next = {lo[XLEN-2:0], take};
    end else begin
      hi_next = sum[XLEN:1];
      lo_next = {sum[0], lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/mips_muldiv_ctrl.sv
// Iterative MIPS64 R6 multiply/divide unit: request/response handshakes,
// operand preparation, N-step iteration and sign/half selection.
module mips_muldiv_ctrl
  import mips_define::*;
#(
  parameter int XLEN      = 64,
  parameter int TAG_W     = 5,
  parameter bit FAST_ZERO = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [XLEN-1:0]  req_a,
  input  logic [XLEN-1:0]  req_b,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             busy
);

  localparam int HALF  = XLEN / 2;
  localparam int CNT_W = $clog2(XLEN);

  muldiv_state_t    state_reg;
  muldiv_op_t       op_reg;
  logic [XLEN-1:0]  a_reg, b_reg, m_reg, hi_reg, lo_reg, resp_data_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             neg_q_reg, neg_r_reg, div_zero_reg;
  logic             resp_valid_reg, req_ready_reg, busy_reg;
  logic [TAG_W-1:0] resp_tag_reg;

  logic            is_dbl, is_div, is_uns, is_hi;
  logic [XLEN-1:0] ext_a, ext_b, mag_a, mag_b;
  logic            sa, sb, any_zero;
  logic [XLEN-1:0] hi_next, lo_next;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0] quo, rem, res, fix_result;

  function automatic logic [XLEN-1:0] extend_word(input logic [XLEN-1:0] v, input logic sgn);
    return {{HALF{sgn & v[HALF-1]}}, v[HALF-1:0]};
  endfunction

  assign is_dbl = op_reg[3];
  assign is_div = op_reg[2];
  assign is_uns = op_reg[1];
  assign is_hi  = op_reg[0];

  always_comb begin
    ext_a    = is_dbl ? a_reg : extend_word(a_reg, ~is_uns);
    ext_b    = is_dbl ? b_reg : extend_word(b_reg, ~is_uns);
    sa       = ~is_uns & ext_a[XLEN-1];
    sb       = ~is_uns & ext_b[XLEN-1];
    mag_a    = sa ? -ext_a : ext_a;
    mag_b    = sb ? -ext_b : ext_b;
    any_zero = (ext_a == '0) || (ext_b == '0);
  end

  mips_muldiv_iter #(.XLEN(XLEN)) u_iter (
    .is_div  (is_div),
    .hi      (hi_reg),
    .lo      (lo_reg),
    .m       (m_reg),
    .hi_next (hi_next),
    .lo_next (lo_next)
  );

  // A word multiply leaves its 64-bit product at {hi[31:0], lo[63:32]} after 32 steps.
  always_comb begin
    prod   = is_dbl ? {hi_reg, lo_reg} : {{HALF{1'b0}}, hi_reg, lo_reg[XLEN-1:HALF]};
    prod_s = neg_q_reg ? -prod : prod;
    quo    = div_zero_reg ? '1 : (neg_q_reg ? -lo_reg : lo_reg);
    rem    = div_zero_reg ? a_reg : (neg_r_reg ? -hi_reg : hi_reg);
    if (is_div)
      res = is_hi ? rem : quo;
    else if (is_hi)
      res = is_dbl ? prod_s[2*XLEN-1:XLEN] : {{HALF{1'b0}}, prod_s[XLEN-1:HALF]};
    else
      res = prod_s[XLEN-1:0];
    fix_result = is_dbl ? res : extend_word(res, 1'b1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      op_reg         <= OP_MUL;
      a_reg          <= '0;
      b_reg          <= '0;
      m_reg          <= '0;
      hi_reg         <= '0;
      lo_reg         <= '0;
      cnt_reg        <= '0;
      neg_q_reg      <= 1'b0;
      neg_r_reg      <= 1'b0;
      div_zero_reg   <= 1'b0;
      resp_data_reg  <= '0;
      resp_tag_reg   <= '0;
      resp_valid_reg <= 1'b0;
      req_ready_reg  <= 1'b1;
      busy_reg       <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req_valid && req_ready_reg && !flush) begin
            op_reg        <= muldiv_op_t'(req_op);
            a_reg         <= req_a;
            b_reg         <= req_b;
            resp_tag_reg  <= req_tag;
            req_ready_reg <= 1'b0;
            busy_reg      <= 1'b1;
            state_reg     <= ST_PREP;
          end
        end
        ST_PREP: begin
          if (flush) begin
            state_reg     <= ST_IDLE;
            req_ready_reg <= 1'b1;
            busy_reg      <= 1'b0;
          end else begin
            a_reg        <= ext_a;
            m_reg        <= is_div ? mag_b : mag_a;
            hi_reg       <= '0;
            lo_reg       <= is_div ? (is_dbl ? mag_a : {mag_a[HALF-1:0], {HALF{1'b0}}}) : mag_b;
            neg_q_reg    <= sa ^ sb;
            neg_r_reg    <= sa;
            div_zero_reg <= (ext_b == '0);
            cnt_reg      <= is_dbl ? CNT_W'(XLEN - 1) : CNT_W'(HALF - 1);
            if (FAST_ZERO && any_zero) begin
              lo_reg    <= '0;
              state_reg <= ST_FIX;
            end else begin
              state_reg <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (flush) begin
            state_reg     <= ST_IDLE;
            req_ready_reg <= 1'b1;
            busy_reg      <= 1'b0;
          end else begin
            hi_reg <= hi_next;
            lo_reg <= lo_next;
            if (cnt_reg == '0)
              state_reg <= ST_FIX;
            else
              cnt_reg <= cnt_reg - 1'b1;
          end
        end
        ST_FIX: begin
          if (flush) begin
            state_reg     <= ST_IDLE;
            req_ready_reg <= 1'b1;
            busy_reg      <= 1'b0;
          end else begin
            resp_data_reg  <= fix_result;
            resp_valid_reg <= 1'b1;
            state_reg      <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (resp_ready) begin
            resp_valid_reg <= 1'b0;
            req_ready_reg  <= 1'b1;
            busy_reg       <= 1'b0;
            state_reg      <= ST_IDLE;
          end
        end
        default: begin
          state_reg     <= ST_IDLE;
          req_ready_reg <= 1'b1;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_reg;
  assign resp_valid = resp_valid_reg;
  assign resp_data  = resp_data_reg;
  assign resp_tag   = resp_tag_reg;
  assign busy       = busy_reg;

endmodule

// File: tb/tb_mips_muldiv_ctrl.sv
// Randomized and directed bench for mips_muldiv_ctrl against a wide-arithmetic
// reference model.
module tb_mips_muldiv_ctrl;
  import mips_define::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = 4'd0;
  logic [63:0] req_a = '0;
  logic [63:0] req_b = '0;
  logic [4:0]  req_tag = '0;
  logic        flush = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [63:0] resp_data;
  logic [4:0]  resp_tag;
  logic        busy;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mips_muldiv_ctrl #(.XLEN(64), .TAG_W(5), .FAST_ZERO(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_tag    (req_tag),
    .flush      (flush),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_tag   (resp_tag),
    .busy       (busy)
  );

  // Exact 128-bit signed arithmetic, then the MIPS result-width rules.
  function automatic logic [63:0] ref_model(input logic [3:0] op, input logic [63:0] a,
                                            input logic [63:0] b);
    logic signed [127:0] x, y, p, q, r;
    logic [63:0] res;
    logic dbl, dv, uns, hi;
    dbl = op[3]; dv = op[2]; uns = op[1]; hi = op[0];
    if (dbl) begin
      x = uns ? {64'd0, a} : {{64{a[63]}}, a};
      y = uns ? {64'd0, b} : {{64{b[63]}}, b};
    end else begin
      x = uns ? {96'd0, a[31:0]} : {{96{a[31]}}, a[31:0]};
      y = uns ? {96'd0, b[31:0]} : {{96{b[31]}}, b[31:0]};
    end
    if (!dv) begin
      p = x * y;
      if (dbl) res = hi ? p[127:64] : p[63:0];
      else     res = hi ? {32'd0, p[63:32]} : p[63:0];
    end else begin
      if (y == 0) begin
        q = '1;
        r = x;
      end else begin
        q = x / y;
        r = x % y;
      end
      res = hi ? r[63:0] : q[63:0];
    end
    if (!dbl) res = {{32{res[31]}}, res[31:0]};
    return res;
  endfunction

  // Edges counted after the accept edge until resp_valid is seen.
  function automatic int ref_latency(input logic [3:0] op, input logic [63:0] a,
                                     input logic [63:0] b);
    logic za, zb;
    za = op[3] ? (a == 64'd0) : (a[31:0] == 32'd0);
    zb = op[3] ? (b == 64'd0) : (b[31:0] == 32'd0);
    if (za || zb) return 2;
    return (op[3] ? 64 : 32) + 2;
  endfunction

  function automatic logic [63:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return 64'd1;
      2: return '1;
      3: return 64'h8000_0000_0000_0000;
      4: return 64'h0000_0000_8000_0000;
      5: return 64'hFFFF_FFFF_FFFF_FFFE;
      6: return 64'($urandom_range(0, 1000));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] tag, input int hold, input logic [63:0] exp,
                        input string name);
    int lat;
    int exp_lat;
    exp_lat = ref_latency(op, a, b);
    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s req_ready_idle: got %b expected 1", name, req_ready);
    end
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
    @(posedge clk); #1;
    req_valid = 1'b0; req_a = {$urandom, $urandom}; req_b = {$urandom, $urandom};
    req_tag = 5'($urandom);
    tests_run++;
    if (busy !== 1'b1 || req_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s busy_after_accept: got busy=%b req_ready=%b expected 1/0", name, busy, req_ready);
    end
    lat = 0;
    while (resp_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    tests_run++;
    if (lat != exp_lat) begin
      tests_failed++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    tests_run++;
    if (resp_data !== exp || resp_tag !== tag) begin
      tests_failed++;
      $display("FAIL %s result: got data=%h tag=%0d expected data=%h tag=%0d",
               name, resp_data, resp_tag, exp, tag);
    end
    $display("[TB] %s op=%0d a=%h b=%h tag=%0d -> %h lat=%0d", name, op, a, b, tag, resp_data, lat);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if (resp_valid !== 1'b1 || resp_data !== exp || resp_tag !== tag || req_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL %s hold_stable: got v=%b data=%h tag=%0d rdy=%b expected 1 %h %0d 0",
                 name, resp_valid, resp_data, resp_tag, req_ready, exp, tag);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    tests_run++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s drain: got v=%b rdy=%b busy=%b expected 0 1 0", name, resp_valid, req_ready, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_data !== 64'd0 ||
        resp_tag !== 5'd0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got rdy=%b v=%b data=%h tag=%0d busy=%b expected 1 0 0 0 0",
               req_ready, resp_valid, resp_data, resp_tag, busy);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
  } vec_t;

  task automatic test_directed();
    vec_t v [10];
    v[0] = '{4'd4,  64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD};
    v[1] = '{4'd5,  64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1};
    v[2] = '{4'd9,  64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF};
    v[3] = '{4'd11, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1};
    v[4] = '{4'd12, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000};
    v[5] = '{4'd13, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0};
    v[6] = '{4'd6,  64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF};
    v[7] = '{4'd7,  64'd5, 64'd0, 64'd5};
    v[8] = '{4'd0,  64'd0, 64'd1234, 64'd0};
    v[9] = '{4'd2,  64'd3, 64'd4, 64'd12};
    for (int i = 0; i < 10; i++)
      run_op(v[i].op, v[i].a, v[i].b, 5'(i + 1), (i == 2) ? 5 : 0, v[i].exp, $sformatf("directed%0d", i));
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [63:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = pick_operand();
      b  = pick_operand();
      run_op(op, a, b, 5'($urandom), $urandom_range(0, 2), ref_model(op, a, b),
             $sformatf("random%0d", i));
    end
  endtask

  task automatic test_flush_run();
    int seen;
    req_valid = 1'b1; req_op = 4'd12; req_a = 64'd1000; req_b = 64'd7; req_tag = 5'd17;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_run_abort: got busy=%b rdy=%b v=%b expected 0 1 0", busy, req_ready, resp_valid);
    end
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (resp_valid === 1'b1 || busy === 1'b1) seen++;
    end
    tests_run++;
    if (seen != 0) begin
      tests_failed++;
      $display("FAIL flush_run_no_resp: got %0d active cycles expected 0", seen);
    end
    $display("[TB] flush_run DDIV squashed in RUN cycle 10");
    run_op(4'd2, 64'd3, 64'd4, 5'd22, 0, 64'd12, "after_flush_mulu");
  endtask

  task automatic test_flush_idle();
    req_valid = 1'b1; req_op = 4'd2; req_a = 64'd9; req_b = 64'd9; req_tag = 5'd4;
    flush = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_idle_reject: got busy=%b rdy=%b expected 0 1", busy, req_ready);
    end
    $display("[TB] flush_idle request with flush not accepted");
  endtask

  task automatic test_flush_done();
    int lat;
    req_valid = 1'b1; req_op = 4'd0; req_a = 64'd6; req_b = 64'd7; req_tag = 5'd11;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (resp_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    tests_run++;
    if (resp_valid !== 1'b1 || resp_data !== 64'd42 || resp_tag !== 5'd11) begin
      tests_failed++;
      $display("FAIL flush_done_ignored: got v=%b data=%h tag=%0d expected 1 %h 11",
               resp_valid, resp_data, resp_tag, 64'd42);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    tests_run++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_done_drain: got v=%b rdy=%b expected 0 1", resp_valid, req_ready);
    end
    $display("[TB] flush_done MUL 6x7 drained after flush in DONE");
  endtask

  task automatic test_reset_mid_run();
    req_valid = 1'b1; req_op = 4'd12; req_a = 64'd12345; req_b = 64'd17; req_tag = 5'd30;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_data !== 64'd0 ||
        resp_tag !== 5'd0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_run: got rdy=%b v=%b data=%h tag=%0d busy=%b expected 1 0 0 0 0",
               req_ready, resp_valid, resp_data, resp_tag, busy);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    $display("[TB] reset_mid_run DDIV aborted by reset");
    repeat (70) @(posedge clk);
    #1;
    tests_run++;
    if (resp_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_no_resp: got v=%b busy=%b expected 0 0", resp_valid, busy);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_flush_run();
    test_flush_idle();
    test_flush_done();
    run_op(4'd0, 64'd3, 64'd5, 5'd9, 0, 64'd15, "pre_reset_mul");
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
